// File: rtl/switch_pkg.sv
// Shared definitions for the push-switch conditioning slice.
//   state_t             : debounce filter states (STABLE, FILTER)
//   CLK_HZ              : system clock frequency
//   DEBOUNCE_MS_DEFAULT : default settle time in milliseconds
//   cycles_from_ms()    : converts a settle time in ms to clock cycles
package switch_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    FILTER = 1'b1
  } state_t;

  localparam int CLK_HZ              = 25_000_000;
  localparam int DEBOUNCE_MS_DEFAULT = 10;

  function automatic int cycles_from_ms(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/switch_sync.sv
// N-stage synchroniser for an asynchronous single-bit input.
// Ports:
//   clk   : system clock (rising edge)
//   reset : synchronous, active-high; loads every stage with RESET_LEVEL
//   d     : asynchronous input
//   q     : synchronised output (last stage of the chain)
module switch_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_p0 <= {STAGES{RESET_LEVEL}};
    end else begin
      chain_p0 <= {chain_p0[STAGES-2:0], d};
    end
  end

  assign q = chain_p0[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Debouncer for a mechanical push-switch: synchronises the raw pin, then
// only accepts a new level after it has been stable for DEBOUNCE_LIMIT
// consecutive cycles at the synchroniser output.
// Ports:
//   i_Clk    : 25 MHz system clock (rising edge)
//   i_Reset  : synchronous, active-high reset
//   i_Switch : raw, asynchronous, bouncy switch pin
//   o_Switch : debounced, registered level
//   o_Rise   : one-cycle strobe when o_Switch goes 0->1
//   o_Fall   : one-cycle strobe when o_Switch goes 1->0
// Build option: define SWITCH_EDGE_STROBE_EN to build the rise/fall strobe
// registers; otherwise o_Rise/o_Fall are tied low (o_Switch is unaffected).
module switch_debounce
  import switch_pkg::*;
#(
  parameter int   DEBOUNCE_LIMIT = cycles_from_ms(DEBOUNCE_MS_DEFAULT),
  parameter int   SYNC_STAGES    = 2,
  parameter logic RESET_LEVEL    = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] count;
  logic             level;

  // Synchroniser: the filter only ever looks at its last stage.
  switch_sync #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (i_Clk),
    .reset (i_Reset),
    .d     (i_Switch),
    .q     (s)
  );

  // Stability filter: any return of s to the current level drops back to
  // STABLE with a zero count, so partial counts never accumulate.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= STABLE;
      count <= '0;
      level <= RESET_LEVEL;
    end else begin
      case (state)
        STABLE: begin
          count <= '0;
          if (s != level) begin
            if (DEBOUNCE_LIMIT == 1) begin
              level <= s;
            end else begin
              state <= FILTER;
              count <= CNT_W'(1);
            end
          end
        end
        FILTER: begin
          if (s == level) begin
            state <= STABLE;
            count <= '0;
          end else if (count == CNT_LAST) begin
            level <= s;
            count <= '0;
            state <= STABLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          count <= '0;
        end
      endcase
    end
  end

  assign o_Switch = level;

`ifdef SWITCH_EDGE_STROBE_EN
  logic flip;
  logic rise_p1;
  logic fall_p1;

  // flip is high exactly when the filter will load s into level this edge,
  // so the strobes register alongside the new level.
  assign flip = (s != level) &&
                (((state == STABLE) && (DEBOUNCE_LIMIT == 1)) ||
                 ((state == FILTER) && (count == CNT_LAST)));

  // Strobe stage: registered together with level.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
    end else begin
      rise_p1 <= flip & s;
      fall_p1 <= flip & ~s;
    end
  end

  assign o_Rise = rise_p1;
  assign o_Fall = fall_p1;
`else
  assign o_Rise = 1'b0;
  assign o_Fall = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed testbench for switch_debounce (DEBOUNCE_LIMIT=4, SYNC_STAGES=2,
// RESET_LEVEL=0). Strobe expectations follow the SWITCH_EDGE_STROBE_EN build.
module tb_switch_debounce;
  import switch_pkg::*;

`ifdef SWITCH_EDGE_STROBE_EN
  localparam bit STROBES_ON = 1'b1;
`else
  localparam bit STROBES_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;
  logic o_sw;
  logic rise;
  logic fall;

  int n_checks = 0;
  int n_fail   = 0;

  switch_debounce #(
    .DEBOUNCE_LIMIT (4),
    .SYNC_STAGES    (2),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .i_Clk    (clk),
    .i_Reset  (rst),
    .i_Switch (sw),
    .o_Switch (o_sw),
    .o_Rise   (rise),
    .o_Fall   (fall)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic strb(input logic v);
    return v & STROBES_ON;
  endfunction

  // One rising edge, then sample/drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_sw, input logic e_rise, input logic e_fall);
    check({tag, ".sw"},   32'(o_sw), 32'(e_sw));
    check({tag, ".rise"}, 32'(rise), 32'(strb(e_rise)));
    check({tag, ".fall"}, 32'(fall), 32'(strb(e_fall)));
  endtask

  // Stimulus already applied before edge E; the new level must appear on
  // edge E+5 (SYNC_STAGES + DEBOUNCE_LIMIT - 1) with a single strobe.
  task automatic expect_change(input string tag, input logic nv);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 6) check_outs(tag, nv, nv, ~nv);
      else        check_outs(tag, ~nv, 1'b0, 1'b0);
    end
    tick();
    check_outs({tag, ".after"}, nv, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic sw_val, input int cycles);
    rst = 1'b1;
    sw  = sw_val;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_outs("reset", 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
  endtask

  bit pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    #1;
    // Reset with the pin high, then release: rising edge after latency.
    do_reset(1'b1, 3);
    expect_change("rst_rel", 1'b1);

    // Clean press and release.
    do_reset(1'b0, 2);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_outs("idle", 1'b0, 1'b0, 1'b0);
    end
    sw = 1'b1;
    expect_change("press", 1'b1);
    sw = 1'b0;
    expect_change("release", 1'b0);

    // Bounce: only the final run of 1s (starting at pattern index 7) counts.
    for (int i = 0; i <= 12; i++) begin
      sw = (i < 8) ? 1'(pat[i]) : 1'b1;
      tick();
      check_outs("bounce", 1'(i >= 12), 1'(i == 12), 1'b0);
    end
    tick();
    check_outs("bounce.after", 1'b1, 1'b0, 1'b0);

    // Glitch rejection: 3-cycle pulse filtered out.
    do_reset(1'b0, 2);
    for (int i = 0; i < 10; i++) begin
      sw = 1'(i < 3);
      tick();
      check_outs("glitch3", 1'b0, 1'b0, 1'b0);
    end
    // 4-cycle pulse passes: rise at E+5, fall at E+9.
    for (int i = 0; i < 12; i++) begin
      sw = 1'(i < 4);
      tick();
      check_outs("pulse4", 1'(i >= 5 && i < 9), 1'(i == 5), 1'(i == 9));
    end

    // Reset in the middle of a filter run.
    sw = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid.count", 32'(dut.count), 32'd2);
    check("mid.state", 32'(dut.state), 32'(FILTER));
    rst = 1'b1;
    tick();
    check("mid_rst.count", 32'(dut.count), 32'd0);
    check("mid_rst.state", 32'(dut.state), 32'(STABLE));
    check_outs("mid_rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    sw  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_outs("mid_post", 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
